// File: rtl/pulse_sync_pkg.sv
// Shared types and default timing for the cross-domain pulse path (transmitter and receiver).
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_tx_state_t;

    localparam int DEFAULT_HIGH_CYCLES = 11;
    localparam int DEFAULT_GAP_CYCLES  = 4;
    localparam int DEFAULT_PEND_W      = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter: updates on the edge after inc/dec; inc+dec together is a no-op.
// When full, a lone inc is refused and flagged on drop_o; a lone dec at zero is ignored.
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);

    logic [W-1:0] count_q, count_d;

    assign full_o  = &count_q;
    assign empty_o = (count_q == '0);
    assign drop_o  = inc_i & ~dec_i & full_o;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pulse_stretch_tx.sv
// Stretches single-cycle strobes into HIGH_CYCLES-wide pulses separated by GAP_CYCLES lows; out rises 1 cycle
// after a strobe. Strobes arriving mid-pulse queue in a saturating counter; drops when full set sticky overflow.
module pulse_stretch_tx
    import pulse_sync_pkg::*;
#(
    parameter int HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int PEND_W      = DEFAULT_PEND_W
) (
    input  logic              in_clk,
    input  logic              rst_n,
    input  logic              strobe,
    input  logic              clr_overflow,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int CNT_W = $clog2(max2(HIGH_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    if (HIGH_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
        $error("pulse_stretch_tx: HIGH_CYCLES and GAP_CYCLES must both be >= 1");
    end

    pulse_tx_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             start, strobe_used;
    logic             pend_inc, pend_dec, pend_full, pend_empty, pend_drop;

    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    // A queued event always goes before a fresh strobe; the strobe then joins the queue.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start       = 1'b0;
        strobe_used = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe || !pend_empty) start = 1'b1;
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (strobe || !pend_empty) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d     = HIGH;
            cnt_d       = HIGH_LOAD;
            strobe_used = pend_empty;
        end
    end

    always_comb begin
        out_d = (state_d == HIGH);
        ovf_d = ovf_q;
        if (pend_drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    assign pend_inc = strobe & ~strobe_used;
    assign pend_dec = start & ~pend_empty;

    sat_updown_counter #(
        .W(PEND_W)
    ) u_pend (
        .clk_i   (in_clk),
        .rst_n_i (rst_n),
        .inc_i   (pend_inc),
        .dec_i   (pend_dec),
        .count_o (pending),
        .full_o  (pend_full),
        .empty_o (pend_empty),
        .drop_o  (pend_drop)
    );

    assign out      = out_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) || !pend_empty;

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// Randomised and directed bench for pulse_stretch_tx against an event-schedule model.
module tb_pulse_stretch_tx;
    import pulse_sync_pkg::*;

    localparam int H    = DEFAULT_HIGH_CYCLES;
    localparam int G    = DEFAULT_GAP_CYCLES;
    localparam int PW   = DEFAULT_PEND_W;
    localparam int PMAX = (1 << PW) - 1;
    localparam int P    = H + G;

    logic          in_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          strobe = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_stretch_tx #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_W     (PW)
    ) u_dut (
        .in_clk      (in_clk),
        .rst_n       (rst_n),
        .strobe      (strobe),
        .clr_overflow(clr_overflow),
        .out         (out),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 in_clk = ~in_clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model: every accepted event has a start edge; out/busy/pending follow from that schedule.
    int m_q[$];
    int last_s = -1000;
    bit m_ovf = 0;
    int edge_n = 0;

    int t_rise, t_high, t_busy, t_pend_peak, t_gap_min, t_gap_run, t_rx;
    bit prev_out = 0, seen_pulse = 0;
    int div = 0;
    bit s1 = 0, s2 = 0, s3 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(posedge in_clk) begin : p_model
        int  s;
        int  cnt;
        bit  drop;
        bit  e_out;
        bit  e_busy;
        int  e_pend;
        if (!rst_n) begin
            m_q.delete();
            last_s = -1000;
            m_ovf  = 0;
        end else begin
            while (m_q.size() > 0 && m_q[0] + P <= edge_n) void'(m_q.pop_front());
            drop = 0;
            if (strobe) begin
                s   = (last_s + P > edge_n) ? last_s + P : edge_n;
                cnt = 0;
                foreach (m_q[i]) if (m_q[i] > edge_n) cnt++;
                if (s > edge_n && cnt == PMAX) begin
                    drop = 1;
                end else begin
                    m_q.push_back(s);
                    last_s = s;
                end
            end
            if (drop) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
        end
        e_out = 0; e_busy = 0; e_pend = 0;
        foreach (m_q[i]) begin
            if (m_q[i] <= edge_n && edge_n < m_q[i] + H) e_out = 1;
            if (m_q[i] <= edge_n && edge_n < m_q[i] + P) e_busy = 1;
            if (m_q[i] > edge_n) e_pend++;
        end
        if (e_pend > 0) e_busy = 1;
        #1;
        if (chk_en) begin
            chk("cyc_out", out, e_out);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_pending", pending, e_pend);
            chk("cyc_overflow", overflow, m_ovf);
        end
        if (out && !prev_out) begin
            t_rise++;
            if (seen_pulse && t_gap_run < t_gap_min) t_gap_min = t_gap_run;
            seen_pulse = 1;
        end
        if (out) t_gap_run = 0; else t_gap_run++;
        t_high += int'(out);
        t_busy += int'(busy);
        if (int'(pending) > t_pend_peak) t_pend_peak = int'(pending);
        // Destination receiver at one third of in_clk: two-flop sync plus rising-edge detect.
        div = (div == 2) ? 0 : div + 1;
        if (div == 0) begin
            s3 = s2; s2 = s1; s1 = out;
            if (s2 && !s3) t_rx++;
        end
        prev_out = out;
        edge_n++;
    end

    task automatic clear_tallies();
        t_rise = 0; t_high = 0; t_busy = 0; t_pend_peak = 0;
        t_gap_min = 1000; t_gap_run = 0; t_rx = 0; seen_pulse = 0;
    endtask

    task automatic step(input bit s, input bit c, input bit r);
        strobe = s; clr_overflow = c; rst_n = r;
        @(negedge in_clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            step(0, 0, 1);
            n++;
        end
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        clear_tallies();
        @(negedge in_clk);
        step(0, 0, 0);
        chk_en = 1;
        step(0, 0, 0);
        chk("rst_out", out, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        repeat (9) step(0, 0, 1);

        // Single strobe: 11 high, busy for 11+4, nothing queued.
        clear_tallies();
        step(1, 0, 1);
        chk("single_latency", out, 1);
        repeat (20) step(0, 0, 1);
        chk("single_rise", t_rise, 1);
        chk("single_high", t_high, 11);
        chk("single_busy", t_busy, 15);
        chk("single_peak", t_pend_peak, 0);

        // Three strobes two cycles apart.
        clear_tallies();
        step(1, 0, 1); step(0, 0, 1);
        step(1, 0, 1); step(0, 0, 1);
        step(1, 0, 1);
        chk("three_pend", pending, 2);
        wait_idle(200, "three");
        chk("three_rise", t_rise, 3);
        chk("three_high", t_high, 33);
        chk("three_gap", t_gap_min, 4);
        chk("three_peak", t_pend_peak, 2);
        chk("three_rx", t_rx, 3);

        // Strobe held 20 cycles; the first queued event dequeues on the 16th edge, so
        // 18 events are accepted in total including the later strobe at edge 30.
        clear_tallies();
        repeat (20) step(1, 0, 1);
        chk("hold_peak", t_pend_peak, 15);
        chk("hold_ovf", overflow, 1);
        repeat (5) step(0, 0, 1);
        step(0, 1, 1);
        chk("clr_ovf", overflow, 0);
        repeat (4) step(0, 0, 1);
        step(1, 0, 1);
        chk("full_deq_pend", pending, 15);
        chk("full_deq_ovf", overflow, 0);
        step(1, 1, 1);
        chk("drop_clr_ovf", overflow, 1);
        chk("drop_clr_pend", pending, 15);
        wait_idle(400, "hold");
        chk("hold_rise", t_rise, 18);

        // Reset mid-pulse with three queued events.
        clear_tallies();
        repeat (4) step(1, 0, 1);
        step(0, 0, 1);
        chk("pre_rst_pend", pending, 3);
        step(1, 0, 0);
        chk("midrst_out", out, 0);
        chk("midrst_pend", pending, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_busy", busy, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 1);
        chk("post_rst_out", out, 0);
        chk("post_rst_busy", busy, 0);
        clear_tallies();
        step(1, 0, 1);
        repeat (20) step(0, 0, 1);
        chk("post_rst_rise", t_rise, 1);
        chk("post_rst_high", t_high, 11);

        // Random traffic with varying density, clears and rare resets.
        for (int blk = 0; blk < 15; blk++) begin
            int dens;
            dens = $urandom_range(0, 100);
            for (int k = 0; k < 200; k++) begin
                step($urandom_range(0, 99) < dens,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 599) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
